// File: rtl/wave_seq_pkg.sv
// Shared definitions for the note sequencer.
//   SCALE_W : width of the Scale value handed to the sawtooth generator
//   state_e : sequencer control states
package wave_seq_pkg;

  localparam int unsigned SCALE_W = 6;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPlay,
    StFinish
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV cycles while run is high.
//   sysclk : clock
//   rst_n  : asynchronous active-low reset
//   clear  : synchronous clear, restarts the count so the next tick is TICK_DIV cycles away
//   run    : count enable
//   tick   : high for one cycle on the last count of each TICK_DIV period
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LastCnt = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= (cnt_q == LastCnt) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick = run && (cnt_q == LastCnt);

endmodule

// File: rtl/wave_note_sequencer.sv
// Steps the sawtooth generator through a programmable table of {scale, duration} notes.
//   sysclk, rst_n          : clock, asynchronous active-low reset (also clears the table)
//   start / stop           : one-cycle pulses; stop overrides everything while busy
//   loop_en                : wrap to entry 0 after the last entry instead of finishing
//   cfg_we/addr/scale/dur  : table write port, usable in any state
//   Scale, Enable_SW_1     : generator controls (registered)
//   step_idx, busy, done   : status; done pulses once on normal completion
module wave_note_sequencer
  import wave_seq_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 8,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned DUR_W     = 8
) (
  input  logic                         sysclk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop_en,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr,
  input  logic [SCALE_W-1:0]           cfg_scale,
  input  logic [DUR_W-1:0]             cfg_dur,
  output logic [SCALE_W-1:0]           Scale,
  output logic                         Enable_SW_1,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned IW = $clog2(NUM_STEPS);
  localparam logic [IW-1:0] LastStep = IW'(NUM_STEPS - 1);
  localparam logic [IW:0]   SkipFull = (IW + 1)'(NUM_STEPS);

  typedef struct packed {
    logic [SCALE_W-1:0] scale;
    logic [DUR_W-1:0]   dur;
  } entry_t;

  entry_t tbl_q [NUM_STEPS];

  state_e             state_q, state_d;
  logic [IW-1:0]      step_q, step_d;
  logic [IW:0]        skip_q, skip_d, skip_inc;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic               en_q, en_d;
  logic               done_q, done_d;
  logic               busy_q;
  logic               presc_clr, tick, advance, empty;
  entry_t             cur;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .clear  (presc_clr),
    .run    (state_q == StPlay),
    .tick   (tick)
  );

  // Table write; LOAD samples the pre-edge contents, so a write to the playing entry
  // only shows up on that entry's next LOAD.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) tbl_q[i] <= '0;
    end else if (cfg_we && (32'(cfg_addr) < NUM_STEPS)) begin
      tbl_q[cfg_addr] <= '{scale: cfg_scale, dur: cfg_dur};
    end
  end

  assign cur      = tbl_q[step_q];
  assign skip_inc = skip_q + (IW + 1)'(1);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    skip_d    = skip_q;
    dur_d     = dur_q;
    scale_d   = scale_q;
    en_d      = en_q;
    done_d    = 1'b0;
    presc_clr = 1'b0;
    advance   = 1'b0;
    empty     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StLoad;
          step_d  = '0;
          skip_d  = '0;
        end
      end
      StLoad: begin
        presc_clr = 1'b1;
        if (cur.dur == '0) begin
          skip_d  = skip_inc;
          advance = 1'b1;
          // A full lap of zero-duration entries means nothing can ever play.
          empty   = (skip_inc == SkipFull);
        end else begin
          skip_d  = '0;
          dur_d   = cur.dur;
          scale_d = cur.scale;
          en_d    = (cur.scale != '0);
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (tick) begin
          if (dur_q == DUR_W'(1)) advance = 1'b1;
          else                    dur_d   = dur_q - DUR_W'(1);
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (advance) begin
      if (empty) begin
        state_d = StFinish;
      end else if (step_q == LastStep) begin
        if (loop_en) begin
          step_d  = '0;
          state_d = StLoad;
        end else begin
          state_d = StFinish;
        end
      end else begin
        step_d  = step_q + IW'(1);
        state_d = StLoad;
      end
    end

    if (state_d == StFinish) begin
      done_d  = 1'b1;
      scale_d = '0;
      en_d    = 1'b0;
    end

    // Abort wins over every other transition; step_idx freezes where it was.
    if (stop && (state_q != StIdle)) begin
      state_d = StIdle;
      step_d  = step_q;
      scale_d = '0;
      en_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= '0;
      skip_q  <= '0;
      dur_q   <= '0;
      scale_q <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      skip_q  <= skip_d;
      dur_q   <= dur_d;
      scale_q <= scale_d;
      en_q    <= en_d;
      done_q  <= done_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign Scale       = scale_q;
  assign Enable_SW_1 = en_q;
  assign step_idx    = step_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_wave_note_sequencer.sv
module tb_wave_note_sequencer;

  localparam int NS      = 8;
  localparam int TD      = 4;
  localparam int MAX_LEN = 400;

  typedef struct packed {
    logic [5:0] scale;
    logic       en;
    logic [2:0] step;
    logic       busy;
    logic       done;
  } obs_t;

  logic       sysclk = 1'b0;
  logic       rst_n;
  logic       start, stop, loop_en, cfg_we;
  logic [2:0] cfg_addr;
  logic [5:0] cfg_scale;
  logic [7:0] cfg_dur;
  logic [5:0] Scale;
  logic       Enable_SW_1;
  logic [2:0] step_idx;
  logic       busy, done;

  int total = 0;
  int bad   = 0;

  int   mdl_scale [NS];
  int   mdl_dur   [NS];
  obs_t exp_q[$];

  wave_note_sequencer #(
    .NUM_STEPS (NS),
    .TICK_DIV  (TD),
    .DUR_W     (8)
  ) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_scale   (cfg_scale),
    .cfg_dur     (cfg_dur),
    .Scale       (Scale),
    .Enable_SW_1 (Enable_SW_1),
    .step_idx    (step_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 sysclk = ~sysclk;

  function automatic obs_t mk(int s, bit e, int st, bit b, bit d);
    obs_t o;
    o.scale = 6'(s);
    o.en    = e;
    o.step  = 3'(st);
    o.busy  = b;
    o.done  = d;
    return o;
  endfunction

  // Expected per-cycle trace after a start pulse: each entry costs one LOAD cycle with the
  // previous note still sounding, then dur*TD cycles of its own note. An optional table write
  // lands after cycle wr_c and is seen by any LOAD that follows it.
  function automatic void build_trace(bit lp, int wr_c, int wr_a, int wr_s, int wr_d);
    int  sc [NS];
    int  du [NS];
    int  step = 0, skips = 0, cs = 0;
    bit  ce = 0, fin = 0, wr_done = 0;
    for (int i = 0; i < NS; i++) begin
      sc[i] = mdl_scale[i];
      du[i] = mdl_dur[i];
    end
    exp_q.delete();
    while (!fin && exp_q.size() < MAX_LEN) begin
      if (wr_c >= 0 && !wr_done && exp_q.size() > wr_c) begin
        sc[wr_a] = wr_s;
        du[wr_a] = wr_d;
        wr_done  = 1;
      end
      exp_q.push_back(mk(cs, ce, step, 1, 0));
      if (du[step] == 0) begin
        skips++;
        if (skips == NS) fin = 1;
      end else begin
        skips = 0;
        cs    = sc[step];
        ce    = (sc[step] != 0);
        for (int k = 0; k < du[step] * TD; k++) exp_q.push_back(mk(cs, ce, step, 1, 0));
      end
      if (!fin) begin
        if (step == NS - 1) begin
          if (lp) step = 0;
          else    fin  = 1;
        end else begin
          step++;
        end
      end
    end
    if (fin) begin
      exp_q.push_back(mk(0, 0, step, 1, 1));
      exp_q.push_back(mk(0, 0, step, 0, 0));
    end
  endfunction

  task automatic write_entry(int a, int s, int d);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(a);
    cfg_scale = 6'(s);
    cfg_dur   = 8'(d);
    @(negedge sysclk);
    cfg_we    = 1'b0;
    mdl_scale[a] = s;
    mdl_dur[a]   = d;
  endtask

  task automatic load_basic_table();
    write_entry(0, 10, 2);
    write_entry(1, 20, 1);
    write_entry(2, 0, 3);
    for (int i = 3; i < NS; i++) write_entry(i, 0, 0);
  endtask

  // Pulses start, then checks every cycle of exp_q. stop_at truncates the trace to an IDLE
  // cycle right after the abort; start_at/wr_c inject extra stimulus after that cycle.
  task automatic run_trace(string name, int stop_at, int start_at, int wr_c,
                           int wr_a, int wr_s, int wr_d);
    obs_t got;
    obs_t ex;
    if (stop_at >= 0) begin
      ex = exp_q[stop_at];
      while (exp_q.size() > stop_at + 1) void'(exp_q.pop_back());
      exp_q.push_back(mk(0, 0, int'(ex.step), 0, 0));
    end
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = {Scale, Enable_SW_1, step_idx, busy, done};
      ex  = exp_q[i];
      total++;
      if (got !== ex) begin
        bad++;
        $display("FAIL %s cycle %0d: got scale=%0d en=%b step=%0d busy=%b done=%b, want scale=%0d en=%b step=%0d busy=%b done=%b",
                 name, i, got.scale, got.en, got.step, got.busy, got.done,
                 ex.scale, ex.en, ex.step, ex.busy, ex.done);
      end
      stop   = (i == stop_at);
      start  = (i == start_at);
      cfg_we = (i == wr_c);
      if (i == wr_c) begin
        cfg_addr  = 3'(wr_a);
        cfg_scale = 6'(wr_s);
        cfg_dur   = 8'(wr_d);
      end
      @(negedge sysclk);
    end
    stop   = 1'b0;
    start  = 1'b0;
    cfg_we = 1'b0;
    if (wr_c >= 0) begin
      mdl_scale[wr_a] = wr_s;
      mdl_dur[wr_a]   = wr_d;
    end
  endtask

  task automatic test_reset();
    obs_t got;
    rst_n = 1'b0;
    #1;
    got = {Scale, Enable_SW_1, step_idx, busy, done};
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL reset_initial: got %h want 0", got);
    end
    @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);
    load_basic_table();
    loop_en = 1'b0;
    start   = 1'b1;
    @(negedge sysclk);
    start   = 1'b0;
    repeat (4) @(negedge sysclk);
    total++;
    if (Enable_SW_1 !== 1'b1 || Scale !== 6'd10) begin
      bad++;
      $display("FAIL reset_pre_play: got scale=%0d en=%b want scale=10 en=1", Scale, Enable_SW_1);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {Scale, Enable_SW_1, step_idx, busy, done};
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL reset_async_mid_play: got %h want 0", got);
    end
    @(negedge sysclk);
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) begin
      mdl_scale[i] = 0;
      mdl_dur[i]   = 0;
    end
    build_trace(0, -1, 0, 0, 0);
    run_trace("reset_table_empty", -1, -1, -1, 0, 0, 0);
  endtask

  task automatic test_basic();
    load_basic_table();
    loop_en = 1'b0;
    build_trace(0, -1, 0, 0, 0);
    run_trace("basic_once", -1, -1, -1, 0, 0, 0);
  endtask

  task automatic test_loop_stop();
    load_basic_table();
    loop_en = 1'b1;
    build_trace(1, -1, 0, 0, 0);
    run_trace("loop_then_stop", 45, -1, -1, 0, 0, 0);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL loop_stop_idle: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_empty_table();
    for (int i = 0; i < NS; i++) write_entry(i, 5 * i, 0);
    loop_en = 1'b1;
    build_trace(1, -1, 0, 0, 0);
    run_trace("empty_loop", -1, -1, -1, 0, 0, 0);
  endtask

  task automatic test_live_write();
    load_basic_table();
    loop_en = 1'b1;
    build_trace(1, 3, 0, 30, 1);
    run_trace("live_write", 40, -1, 3, 0, 30, 1);
  endtask

  task automatic test_start_ignored();
    load_basic_table();
    loop_en = 1'b0;
    build_trace(0, -1, 0, 0, 0);
    run_trace("start_while_busy", -1, 5, -1, 0, 0, 0);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (busy !== 1'b0 || Enable_SW_1 !== 1'b0) begin
        bad++;
        $display("FAIL start_stop_idle cyc%0d: got busy=%b en=%b want 0 0", i, busy, Enable_SW_1);
      end
      @(negedge sysclk);
    end
  endtask

  task automatic test_random();
    int stop_at;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NS; i++) write_entry(i, $urandom_range(0, 63), $urandom_range(0, 3));
      loop_en = 1'(it % 2);
      build_trace(loop_en, -1, 0, 0, 0);
      stop_at = -1;
      if (loop_en) stop_at = $urandom_range(1, exp_q.size() - 3);
      run_trace($sformatf("random_%0d", it), stop_at, -1, -1, 0, 0, 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    loop_en   = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_scale = '0;
    cfg_dur   = '0;
    for (int i = 0; i < NS; i++) begin
      mdl_scale[i] = 0;
      mdl_dur[i]   = 0;
    end
    test_reset();
    test_basic();
    test_loop_stop();
    test_empty_table();
    test_live_write();
    test_start_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_note_sequencer.md
Name: wave_note_sequencer

Overview:
Controller that sequences the sawtooth generator through a programmable table of notes. Each table entry holds a Scale value (sets pitch) and a duration in ticks; the block drives the generator's Scale and enable inputs step by step. Software/top-level loads the table, then issues start/stop pulses. It sits between the board-level control logic and the sawtooth generator.

Parameters:
NUM_STEPS, 8, number of table entries (power of 2, 2..16)
TICK_DIV, 50000, sysclk cycles per duration tick (>=2)
DUR_W, 8, width of per-step duration field

Ports:
sysclk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  1-cycle pulse: begin playback at step 0
stop  input  1  1-cycle pulse: abort playback
loop_en  input  1  1 = wrap to step 0 after last step
cfg_we  input  1  table write strobe
cfg_addr  input  clog2(NUM_STEPS)  table entry index
cfg_scale  input  6  Scale value to store (0 = rest)
cfg_dur  input  DUR_W  duration in ticks (0 = skip entry)
Scale  output  6  Scale to generator
Enable_SW_1  output  1  generator enable
step_idx  output  clog2(NUM_STEPS)  current table index
busy  output  1  high in any state except IDLE
done  output  1  1-cycle pulse on normal completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; Scale=0, Enable_SW_1=0, step_idx=0, busy=0, done=0; all table entries {scale=0,dur=0}; prescaler and duration counter cleared.
- All outputs registered.
- Table: cfg_we writes {cfg_scale,cfg_dur} to cfg_addr on the edge; writes accepted in every state; cfg_addr >= NUM_STEPS ignored. A write to the entry currently playing does not affect the running step; it is used at that entry's next LOAD.
- States: IDLE, LOAD, PLAY, FINISH.
- IDLE: Scale=0, Enable_SW_1=0. start=1 -> LOAD, step_idx=0, skip_cnt=0.
- LOAD (1 cycle): read entry[step_idx]; outputs hold prior values.
  - dur==0: skip entry; skip_cnt+1; advance (rule below).
  - dur!=0: skip_cnt=0; dur_cnt=dur; prescaler cleared; Scale=entry.scale; Enable_SW_1=(entry.scale!=0); -> PLAY.
- PLAY: prescaler emits tick every TICK_DIV cycles (first tick TICK_DIV cycles after entry); on tick dur_cnt decrements; tick with dur_cnt==1 -> advance. Step therefore lasts exactly dur*TICK_DIV cycles in PLAY plus 1 LOAD cycle.
- Advance: if skip_cnt reaches NUM_STEPS -> FINISH (empty table guard, regardless of loop_en). Else if step_idx==NUM_STEPS-1: loop_en=1 -> step_idx=0, LOAD; loop_en=0 -> FINISH. Else step_idx+1, LOAD. loop_en sampled at the advance edge.
- FINISH (1 cycle): done=1, Scale=0, Enable_SW_1=0; -> IDLE.
- stop: highest priority. In LOAD/PLAY/FINISH -> IDLE on that edge, Scale=0, Enable_SW_1=0, no done pulse. stop and start same cycle in IDLE: stay IDLE.
- start while busy: ignored.
- Reset mid-playback: immediate return to reset values, table cleared.
- Widths: dur_cnt DUR_W bits, never underflows (reload only from nonzero dur); prescaler clog2(TICK_DIV) bits, wraps at TICK_DIV-1; skip_cnt clog2(NUM_STEPS)+1 bits.

Decomposition:
- Package wave_seq_pkg: state enum (IDLE, LOAD, PLAY, FINISH), SCALE_W=6 constant, table entry struct {scale, dur}.
- Sub-module tick_prescaler: counter with synchronous clear input, 1-cycle tick output every TICK_DIV cycles; used by PLAY.

Test Plan:
- Reset: assert rst_n=0 mid-PLAY -> Scale=0, Enable_SW_1=0, busy=0, step_idx=0 immediately (async); table reads back empty (start -> done after 8 LOAD cycles).
- TICK_DIV=4, table {10,2},{20,1},{0,3}, rest dur=0, loop_en=0; start -> LOAD, Scale=10/En=1 for 8 cycles, LOAD, Scale=20/En=1 for 4, LOAD, En=0 for 12, 5 skip LOADs, done pulse, IDLE.
- Same table, loop_en=1 -> after entry 7 step_idx wraps to 0 and Scale=10 again; no done; stop pulse -> IDLE next edge, En=0, done never asserted.
- All-zero table, loop_en=1, start -> exactly NUM_STEPS LOAD cycles then FINISH, done=1 for one cycle.
- During entry 0 PLAY write entry 0 = {30,1} -> current step keeps Scale=10 full 8 cycles; next loop pass plays Scale=30 for 4 cycles.
- start pulse during PLAY -> ignored (step_idx unchanged); start+stop same cycle in IDLE -> busy stays 0.
